// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first: recovers one byte per frame from the async rx line.
// Good frames update data_8 with a one-cycle rx_done pulse; a low stop bit gives a one-cycle frame_err.
module uart_rx_byte #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_8,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_HALF    = BAUD_CNT_MAX / 2;
  localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_HALF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             rx_s1, rx_s2, rx_s3;
  logic             start_edge;

  assign start_edge = rx_s3 & ~rx_s2;
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data_8    <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      // Preset to idle-high so a line already low at release reads as a start edge.
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE)
        baud_cnt <= '0;
      else if (baud_cnt == CNT_LAST)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (start_edge)
            state <= START;
        end
        START: begin
          if (baud_cnt == CNT_MID && rx_s2)
            state <= IDLE;
          else if (baud_cnt == CNT_LAST) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_cnt == CNT_MID)
            shift[bit_cnt] <= rx_s2;
          if (baud_cnt == CNT_LAST) begin
            if (bit_cnt == 3'd7)
              state <= STOP;
            else
              bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          // Return to IDLE at mid stop bit so a back-to-back start edge is not missed.
          if (baud_cnt == CNT_MID) begin
            state <= IDLE;
            if (rx_s2) begin
              data_8  <= shift;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 10 clk per bit; a negedge monitor counts pulses
// and models the downstream 8-to-64 assembler from the rx_done rising edge.
module tb_uart_rx_byte;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_8;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_byte #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_8    (data_8),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          wide_cnt = 0;
  int          both_cnt = 0;
  int          last_cyc = 0;
  int          min_gap = 1000000;
  bit          have_last = 0;
  bit          prev_done = 0;
  bit          prev_err = 0;
  bit          prev_busy = 0;
  bit          busy_at_done = 1;
  bit          busy_before_done = 0;
  logic [7:0]  got[$];
  logic [63:0] asm_word = '0;

  always @(negedge clk) begin
    cyc++;
    if (rx_done) begin
      if (!prev_done) begin
        done_cnt++;
        got.push_back(data_8);
        asm_word = {data_8, asm_word[63:8]};
        if (have_last && (cyc - last_cyc) < min_gap)
          min_gap = cyc - last_cyc;
        last_cyc         = cyc;
        have_last        = 1;
        busy_at_done     = rx_busy;
        busy_before_done = prev_busy;
      end else begin
        wide_cnt++;
      end
    end
    if (frame_err) begin
      if (!prev_err) err_cnt++;
      else wide_cnt++;
    end
    if (rx_done && frame_err) both_cnt++;
    prev_done = rx_done;
    prev_err  = frame_err;
    prev_busy = rx_busy;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 10-bit frame; each bit lasts 10 clk edges.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data_8 !== 8'h00) begin n_fail++; $display("FAIL reset_data_8 got=%h exp=00", data_8); end
    n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
    // Release with the line already low: that counts as a start bit.
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_byte(8'hC3, 1'b1);
    idle(10);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL release_low_done_count got=%0d exp=1", done_cnt - d0); end
    n_checks++; if (data_8 !== 8'hC3) begin n_fail++; $display("FAIL release_low_data got=%h exp=c3", data_8); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL release_low_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_single_frame;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    idle(10);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
    n_checks++; if (data_8 !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", data_8); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL single_frame_err got=%0d exp=0", err_cnt - e0); end
    n_checks++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL single_pulse_width wide=%0d exp=0", wide_cnt); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done got=%b exp=0", busy_at_done); end
    n_checks++; if (busy_before_done !== 1'b1) begin n_fail++; $display("FAIL single_busy_before_done got=%b exp=1", busy_before_done); end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    got.delete();
    have_last = 0;
    min_gap = 1000000;
    for (int i = 1; i <= 8; i++)
      send_byte(8'(i), 1'b1);
    idle(10);
    n_checks++; if (done_cnt - d0 !== 8) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=8", done_cnt - d0); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(i + 1));
      end
    end
    n_checks++; if (min_gap < 90) begin n_fail++; $display("FAIL b2b_min_gap got=%0d exp>=90", min_gap); end
    n_checks++; if (asm_word !== 64'h0807060504030201) begin n_fail++; $display("FAIL b2b_assembled got=%h exp=0807060504030201", asm_word); end
    n_checks++; if (wide_cnt !== 0 || both_cnt !== 0) begin n_fail++; $display("FAIL b2b_pulse_shape wide=%0d both=%0d exp=0,0", wide_cnt, both_cnt); end
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_during got=%b exp=1", rx_busy); end
    idle(20);
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - e0); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_after got=%b exp=0", rx_busy); end
    n_checks++; if (data_8 !== 8'h08) begin n_fail++; $display("FAIL glitch_data got=%h exp=08", data_8); end
  endtask

  task automatic test_frame_error;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(20);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ferr_done_count got=%0d exp=1", done_cnt - d0); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_err_count got=%0d exp=1", err_cnt - e0); end
    n_checks++; if (data_8 !== 8'h11) begin n_fail++; $display("FAIL ferr_data got=%h exp=11", data_8); end
    n_checks++; if (both_cnt !== 0 || wide_cnt !== 0) begin n_fail++; $display("FAIL ferr_pulse_shape both=%0d wide=%0d exp=0,0", both_cnt, wide_cnt); end
  endtask

  task automatic test_break;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    idle(20);
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL break_err_count got=%0d exp=1", err_cnt - e0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL break_done got=%0d exp=0", done_cnt - d0); end
    n_checks++; if (data_8 !== 8'h11) begin n_fail++; $display("FAIL break_data got=%h exp=11", data_8); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (43) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (data_8 !== 8'h00) begin n_fail++; $display("FAIL midrst_data got=%h exp=00", data_8); end
    n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_done got=%b exp=0", rx_done); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err got=%b exp=0", frame_err); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_busy got=%b exp=0", rx_busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(45);
    n_checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midrst_no_pulse done=%0d err=%0d exp=0,0", done_cnt - d0, err_cnt - e0); end
    send_byte(8'h5A, 1'b1);
    idle(10);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midrst_next_done got=%0d exp=1", done_cnt - d0); end
    n_checks++; if (data_8 !== 8'h5A) begin n_fail++; $display("FAIL midrst_next_data got=%h exp=5a", data_8); end
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    idle(20);
    test_single_frame();
    idle(20);
    test_back_to_back();
    idle(20);
    test_glitch();
    test_frame_error();
    test_break();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial UART receiver, 8N1 (8 data bits, no parity, 1 stop bit), LSB first. It recovers one byte per frame from the asynchronous rx line. It presents the byte on data_8 with a one-cycle rx_done pulse. It sits directly upstream of the 8-to-64 assembler: data_8 feeds that block's byte input, and rx_done feeds its next-byte enable, which is rising-edge detected.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate in baud.
BAUD_CNT_MAX, CLK_FREQ/BAUD_RATE, derived localparam: clocks per bit (434 at defaults).
BAUD_HALF, BAUD_CNT_MAX/2, derived localparam: mid-bit sample point (217 at defaults).

Ports:
clk        input   1  system clock, all logic on rising edge
rst_n      input   1  synchronous reset, active low
rx         input   1  asynchronous serial line, idle high
data_8     output  8  last correctly framed byte
rx_done    output  1  one-cycle pulse: data_8 updated with a new byte
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
rx_busy    output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: synchronous. While rst_n is low at a clk edge:
  - state=IDLE, baud_cnt=0, bit_cnt=0, shift register=0.
  - data_8=8'h00, rx_done=0, frame_err=0, rx_busy=0.
  - Synchronizer flops rx_s1, rx_s2 and edge flop rx_s3 are all set to 1 (idle line).
- Input path: rx goes through 2-flop synchronizer rx_s1 -> rx_s2, then rx_s3 <= rx_s2. Start edge = rx_s3 & ~rx_s2. All sampling uses rx_s2.
- baud_cnt: counts 0..BAUD_CNT_MAX-1 in every state except IDLE, then wraps to 0. Cleared to 0 on entry to START.
- FSM, states IDLE, START, DATA, STOP:
  - IDLE: on start edge -> START, baud_cnt=0. Otherwise stay.
  - START: at baud_cnt==BAUD_HALF, if rx_s2==1 the start bit was a glitch -> IDLE, no output. At baud_cnt==BAUD_CNT_MAX-1 -> DATA, bit_cnt=0.
  - DATA: at baud_cnt==BAUD_HALF, shift[bit_cnt] <= rx_s2 (LSB first). At baud_cnt==BAUD_CNT_MAX-1: if bit_cnt==7 -> STOP; else bit_cnt+1.
  - STOP: at baud_cnt==BAUD_HALF, sample the stop bit, then -> IDLE on the same edge (half-bit early return gives margin for the next start edge).
    - Stop bit 1: data_8 <= shift, rx_done=1.
    - Stop bit 0: frame_err=1; data_8 and rx_done unchanged.
- rx_done and frame_err are registered and high for exactly one clock, the cycle after the stop mid-sample. Never both high together.
- Between pulses, rx_done is low for at least ~9.5 bit times, which guarantees a clean rising edge for the downstream assembler.
- data_8 holds its value until the next good frame; it is never changed by a glitch, a framing error or a mid-frame reset (except reset itself clearing it to 0).
- Latency: start edge detected at 2–3 clk after the rx falling edge. rx_done asserts 1 clk after the stop mid-sample, i.e. about 9*BAUD_CNT_MAX + BAUD_HALF + 1 clk after the START entry.
- Boundary cases:
  - Back-to-back frames (stop bit immediately followed by the next start bit) must be received without loss.
  - Line held low (break): produces one frame_err with byte 0x00 discarded. No further activity until rx returns high and falls again.
  - rx low when reset is released: the synchronizer preset to 1 causes a start edge. This is treated as a normal start bit.
  - rst_n asserted mid-frame: the partial byte is dropped, and no pulse is emitted for it.
- Arithmetic: baud_cnt width is clog2(BAUD_CNT_MAX); bit_cnt is 3 bits. No other arithmetic.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BAUD_CNT_MAX=10 clk/bit and BAUD_HALF=5.
1. Single frame 0xA5 with valid stop bit -> one rx_done pulse exactly 1 clk wide, data_8=8'hA5, frame_err stays 0, rx_busy falls on the cycle of the stop mid-sample.
2. Eight back-to-back frames 0x01..0x08, no idle gap -> eight rx_done pulses each ≥90 clk apart, data_8 matches each byte in turn; the downstream assembler outputs 64'h0807060504030201.
3. rx low for 3 clk then high (glitch) -> START aborts at mid-sample, no rx_done, no frame_err, rx_busy=0 afterwards, data_8 unchanged.
4. Good frame 0x11, then frame 0x3C with stop bit low -> exactly one frame_err pulse, no rx_done for the second frame, data_8 remains 8'h11.
5. rst_n low for 2 clk during data bit 4 of frame 0xFF, then frame 0x5A -> all outputs 0 during reset, no pulse for 0xFF, then rx_done with data_8=8'h5A.
